// File: rtl/sdram_if_pkg.sv
// Shared definitions for the SDRAM stream reader.
// Contents:
//   SDRAM_ADDR_W / SDRAM_DATA_W / SDRAM_BE_W : geometry of the controller's s1 port
//   rd_state_t                               : read-master FSM states
package sdram_if_pkg;
  localparam int SDRAM_ADDR_W = 22;
  localparam int SDRAM_DATA_W = 16;
  localparam int SDRAM_BE_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;
endpackage

// File: rtl/sdram_stream_reader_if.sv
// Bus bundle of the SDRAM stream reader: Avalon-MM read side toward the
// SDRAM controller s1 slave plus the output word stream.
// Modports:
//   master : the reader (drives m_* requests, st_* stream, consumes st_ready)
//   slave  : the SDRAM controller + stream consumer side
//
// Handshakes:
//   Avalon: a request is accepted on a cycle where m_chipselect=1, m_read_n=0
//   and m_waitrequest=0; until then address and strobes stay unchanged.
//   Each accepted read returns exactly one m_readdatavalid cycle, in order.
//   Stream: a word transfers on a cycle where st_valid=1 and st_ready=1;
//   st_data/st_last are stable while st_valid=1 and st_ready=0.
interface sdram_stream_reader_if #(
  parameter int ADDR_W = sdram_if_pkg::SDRAM_ADDR_W,
  parameter int DATA_W = sdram_if_pkg::SDRAM_DATA_W,
  parameter int BE_W   = sdram_if_pkg::SDRAM_BE_W
);
  logic [ADDR_W-1:0] m_address;
  logic [BE_W-1:0]   m_byteenable_n;
  logic              m_chipselect;
  logic              m_read_n;
  logic              m_write_n;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic              m_waitrequest;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_last;

  modport master (
    output m_address, m_byteenable_n, m_chipselect, m_read_n, m_write_n, m_writedata,
    input  m_readdata, m_readdatavalid, m_waitrequest,
    output st_data, st_valid, st_last,
    input  st_ready
  );

  modport slave (
    input  m_address, m_byteenable_n, m_chipselect, m_read_n, m_write_n, m_writedata,
    output m_readdata, m_readdatavalid, m_waitrequest,
    input  st_data, st_valid, st_last,
    output st_ready
  );
endinterface

// File: rtl/sdram_rd_fifo.sv
// Single-clock synchronous FIFO holding returned SDRAM words.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_wr, i_wdata     : push (must not be asserted into a full FIFO without a pop)
//   i_rd              : pop (ignored when empty)
//   o_rdata           : head word, valid whenever o_empty=0
//   o_count           : number of stored entries (0..DEPTH)
//   o_empty, o_full   : status flags
module sdram_rd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_rd,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_rd;

  assign w_rd    = i_rd && !o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(i_wr && o_full && !w_rd));
endmodule

// File: rtl/sdram_stream_reader.sv
// Avalon-MM burst-free read master: on start, fetches word_count consecutive
// 16-bit words from base_addr with pipelined reads and streams them out.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : one-cycle command, ignored while busy
//   base_addr          : first word address (sampled on start)
//   word_count         : number of words (sampled on start, 0 = no-op)
//   busy, done         : block in progress / one-cycle pulse as busy falls
//   dbg_state          : current FSM state
//   bus                : Avalon read master + output stream (master modport)
module sdram_stream_reader import sdram_if_pkg::*; #(
  parameter int ADDR_W     = SDRAM_ADDR_W,
  parameter int DATA_W     = SDRAM_DATA_W,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_PEND   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LEN_W-1:0]        word_count,
  output logic                    busy,
  output logic                    done,
  output rd_state_t               dbg_state,
  sdram_stream_reader_if.master   bus
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  rd_state_t         r_state, w_state_n;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining, r_len, r_popped, w_rem_n;
  logic [PEND_W-1:0] r_pend, w_pend_n;
  logic              r_req, w_req_n;
  logic              r_done, w_done_n;
  logic              w_accept, w_rdv, w_pop, w_last, w_credit;
  logic [CNT_W-1:0]  w_fifo_count, w_cnt_n;
  logic              w_fifo_empty, w_fifo_full;
  int                w_occ;

  // Returns with nothing outstanding (e.g. stragglers after a reset) are dropped.
  assign w_accept = r_req && !bus.m_waitrequest;
  assign w_rdv    = bus.m_readdatavalid && (r_pend != '0);
  assign w_pop    = !w_fifo_empty && bus.st_ready;
  assign w_last   = !w_fifo_empty && (r_state != IDLE) && (r_popped == r_len - 1'b1);
  assign w_rem_n  = w_accept ? r_remaining - 1'b1 : r_remaining;

  always_comb begin
    w_pend_n = r_pend;
    case ({w_accept, w_rdv})
      2'b10:   w_pend_n = r_pend + 1'b1;
      2'b01:   w_pend_n = r_pend - 1'b1;
      default: w_pend_n = r_pend;
    endcase
    w_cnt_n = w_fifo_count;
    case ({w_rdv, w_pop})
      2'b10:   w_cnt_n = w_fifo_count + 1'b1;
      2'b01:   w_cnt_n = w_fifo_count - 1'b1;
      default: w_cnt_n = w_fifo_count;
    endcase
    // Credit is judged on post-edge occupancy: every word already requested
    // or buffered, plus the one about to be presented, must fit the FIFO.
    w_occ    = int'(w_pend_n) + int'(w_cnt_n);
    w_credit = (w_occ + 1 <= FIFO_DEPTH) && (int'(w_pend_n) < MAX_PEND);
  end

  always_comb begin
    w_state_n = r_state;
    w_req_n   = 1'b0;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            w_state_n = ISSUE;
            w_req_n   = w_credit;
          end else begin
            w_done_n  = 1'b1;
          end
        end
      end
      ISSUE: begin
        // A stalled request is held until accepted, regardless of credit.
        if (r_req && bus.m_waitrequest) w_req_n = 1'b1;
        else if (w_rem_n != '0)         w_req_n = w_credit;
        if (w_rem_n == '0) w_state_n = DRAIN;
      end
      DRAIN: begin
        // Popping the final word implies every read has returned.
        if (w_pop && w_last) begin
          w_state_n = IDLE;
          w_done_n  = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_popped    <= '0;
      r_pend      <= '0;
      r_req       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_req  <= w_req_n;
      r_done <= w_done_n;
      r_pend <= w_pend_n;
      if (r_state == IDLE && start && word_count != '0) begin
        r_addr      <= base_addr;
        r_remaining <= word_count;
        r_len       <= word_count;
        r_popped    <= '0;
      end else begin
        if (w_accept) r_addr <= r_addr + 1'b1;
        r_remaining <= w_rem_n;
        if (w_pop) r_popped <= r_popped + 1'b1;
      end
    end
  end

  sdram_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_wr    (w_rdv),
    .i_wdata (bus.m_readdata),
    .i_rd    (w_pop),
    .o_rdata (bus.st_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // Credit accounting must make a return into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!reset_n) !(w_rdv && w_fifo_full && !w_pop));

  assign busy                = (r_state != IDLE);
  assign done                = r_done;
  assign dbg_state           = r_state;
  assign bus.m_address       = r_addr;
  assign bus.m_chipselect    = r_req;
  assign bus.m_read_n        = ~r_req;
  assign bus.m_byteenable_n  = '0;
  assign bus.m_write_n       = 1'b1;
  assign bus.m_writedata     = '0;
  assign bus.st_valid        = !w_fifo_empty;
  assign bus.st_last         = w_last;
endmodule

// File: tb/tb_sdram_stream_reader.sv
// Directed bench for sdram_stream_reader: Avalon slave with fixed read
// latency and scheduled waitrequest stalls, stream sink with an expected
// queue, and a single comparison task feeding the final report.
module tb_sdram_stream_reader;
  import sdram_if_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [21:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  rd_state_t   dbg_state;

  sdram_stream_reader_if bus();

  sdram_stream_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int lat = 3;
  int stall_idx = -1;
  int stall_len = 0;
  int stall_used = 0;
  bit ready_cfg = 1'b1;
  int accepts = 0;
  int pend_m = 0;
  int max_pend = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_pop = -1;
  int start_cyc = -1;
  int first_req = -1;
  int first_rdv = -1;
  int first_valid = -1;
  int first_acc = -1;
  int last_acc = -1;
  logic [21:0] exp_addr;
  int          due_q[$];
  logic [15:0] dat_q[$];
  logic [15:0] exp_q[$];
  logic [21:0] addr_log[$];

  function automatic logic [15:0] mem_f(logic [21:0] a);
    return a[15:0] ^ {a[21:16], 10'h2A5};
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- per-cycle driver / monitor ----------------
  task automatic step();
    logic       present;
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    // slave return path (fixed latency, in order)
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      bus.m_readdatavalid = 1'b1;
      bus.m_readdata      = dat_q.pop_front();
      void'(due_q.pop_front());
      if (pend_m > 0) pend_m--;
      if (first_rdv < 0) first_rdv = cyc;
    end else begin
      bus.m_readdatavalid = 1'b0;
      bus.m_readdata      = '0;
    end
    // slave request path
    present = bus.m_chipselect && !bus.m_read_n;
    if (stall_used > 0 && stall_used < stall_len)
      check_eq("stall_strobe", {30'd0, bus.m_chipselect, bus.m_read_n}, 32'd2);
    if (present && accepts == stall_idx && stall_used < stall_len) begin
      bus.m_waitrequest = 1'b1;
      stall_used++;
      check_eq("stall_addr", bus.m_address, exp_addr);
    end else begin
      bus.m_waitrequest = 1'b0;
    end
    if (present && first_req < 0) first_req = cyc;
    if (present && !bus.m_waitrequest) begin
      check_eq("rd_addr", bus.m_address, exp_addr);
      addr_log.push_back(bus.m_address);
      due_q.push_back(cyc + lat);
      dat_q.push_back(mem_f(bus.m_address));
      exp_addr++;
      accepts++;
      pend_m++;
      if (pend_m > max_pend) max_pend = pend_m;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    // stream sink / scoreboard
    bus.st_ready = ready_cfg;
    if (bus.st_valid && first_valid < 0) first_valid = cyc;
    if (bus.st_valid && bus.st_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_word", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("st_data", bus.st_data, e);
        check_eq("st_last", bus.st_last, (exp_q.size() == 0));
      end
      last_pop = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check_eq("busy_at_done", busy, 32'd0);
    end
  endtask

  task automatic start_block(logic [21:0] b, logic [15:0] n);
    exp_q.delete();
    addr_log.delete();
    for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_f(b + 22'(i)));
    exp_addr    = b;
    accepts     = 0;
    max_pend    = 0;
    first_req   = -1;
    first_rdv   = -1;
    first_valid = -1;
    first_acc   = -1;
    last_acc    = -1;
    stall_used  = 0;
    base_addr   = b;
    word_count  = n;
    start       = 1'b1;
    start_cyc   = cyc;
  endtask

  task automatic run_until_done(int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check_eq("done_seen", done_cnt - d0, 32'd1);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    reset_n = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    bus.m_readdata = '0;
    bus.m_readdatavalid = 1'b0;
    bus.m_waitrequest = 1'b0;
    bus.st_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_done", done, 32'd0);
    check_eq("rst_cs", bus.m_chipselect, 32'd0);
    check_eq("rst_read_n", bus.m_read_n, 32'd1);
    check_eq("rst_addr", bus.m_address, 32'd0);
    check_eq("rst_st_valid", bus.st_valid, 32'd0);
    check_eq("rst_st_last", bus.st_last, 32'd0);
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("write_n", bus.m_write_n, 32'd1);
    check_eq("byteen_n", bus.m_byteenable_n, 32'd0);
    check_eq("writedata", bus.m_writedata, 32'd0);
    run(2);
    reset_n = 1'b1;
    run(2);

    // basic block: 4 words from 0x100, latency 3
    lat = 3; ready_cfg = 1'b1; stall_idx = -1; stall_len = 0;
    start_block(22'h000100, 16'd4);
    run_until_done(200);
    check_eq("basic_req_lat", first_req - start_cyc, 32'd1);
    check_eq("basic_accepts", accepts, 32'd4);
    check_eq("basic_back2back", last_acc - first_acc, 32'd3);
    check_eq("basic_valid_lat", first_valid - first_rdv, 32'd1);
    check_eq("basic_done_lat", done_cyc - last_pop, 32'd1);
    check_eq("basic_all_words", exp_q.size(), 32'd0);
    check_eq("basic_idle", dbg_state, IDLE);
    run(2);

    // waitrequest stall on the second request for 5 cycles
    stall_idx = 1; stall_len = 5;
    start_block(22'h000100, 16'd4);
    run_until_done(200);
    check_eq("stall_cycles", stall_used, 32'd5);
    check_eq("stall_accepts", accepts, 32'd4);
    check_eq("stall_all_words", exp_q.size(), 32'd0);
    stall_idx = -1; stall_len = 0;
    run(2);

    // back-pressure: consumer stalled, issue must stop at FIFO capacity
    ready_cfg = 1'b0;
    start_block(22'h002000, 16'd64);
    run(60);
    check_eq("bp_accepts", accepts, 32'd16);
    check_eq("bp_strobe_off", bus.m_chipselect, 32'd0);
    check_eq("bp_read_n", bus.m_read_n, 32'd1);
    check_eq("bp_busy", busy, 32'd1);
    check_eq("bp_valid", bus.st_valid, 32'd1);
    ready_cfg = 1'b1;
    run_until_done(600);
    check_eq("bp_total", accepts, 32'd64);
    check_eq("bp_all_words", exp_q.size(), 32'd0);
    run(2);

    // pend limit: long latency caps outstanding reads
    lat = 20;
    start_block(22'h003000, 16'd16);
    run_until_done(400);
    check_eq("pend_max", max_pend, 32'd8);
    check_eq("pend_accepts", accepts, 32'd16);
    check_eq("pend_all_words", exp_q.size(), 32'd0);
    lat = 3;
    run(2);

    // address wrap at the top of the SDRAM
    start_block(22'h3FFFFE, 16'd4);
    run_until_done(200);
    check_eq("wrap_n", addr_log.size(), 32'd4);
    if (addr_log.size() == 4) begin
      check_eq("wrap_a0", addr_log[0], 32'h3FFFFE);
      check_eq("wrap_a1", addr_log[1], 32'h3FFFFF);
      check_eq("wrap_a2", addr_log[2], 32'h000000);
      check_eq("wrap_a3", addr_log[3], 32'h000001);
    end
    check_eq("wrap_all_words", exp_q.size(), 32'd0);
    run(2);

    // zero-length command: done pulse only
    n = done_cnt;
    start_block(22'h000055, 16'd0);
    step();
    check_eq("zero_done", done, 32'd1);
    check_eq("zero_busy", busy, 32'd0);
    run(5);
    check_eq("zero_one_pulse", done_cnt - n, 32'd1);
    check_eq("zero_no_read", (first_req < 0), 32'd1);
    check_eq("zero_accepts", accepts, 32'd0);

    // asynchronous reset with three reads outstanding
    lat = 6;
    start_block(22'h000400, 16'd16);
    n = 0;
    while (accepts < 3 && n < 50) begin
      step();
      n++;
    end
    check_eq("mid_accepts", accepts, 32'd3);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_cs", bus.m_chipselect, 32'd0);
    check_eq("mid_rst_read_n", bus.m_read_n, 32'd1);
    check_eq("mid_rst_addr", bus.m_address, 32'd0);
    check_eq("mid_rst_busy", busy, 32'd0);
    check_eq("mid_rst_valid", bus.st_valid, 32'd0);
    check_eq("mid_rst_state", dbg_state, IDLE);
    exp_q.delete();
    run(2);
    reset_n = 1'b1;
    run(12);
    check_eq("late_rdv_dropped", bus.st_valid, 32'd0);
    check_eq("late_q_drained", due_q.size(), 32'd0);
    lat = 3;
    start_block(22'h000500, 16'd4);
    run_until_done(200);
    check_eq("post_rst_accepts", accepts, 32'd4);
    check_eq("post_rst_all_words", exp_q.size(), 32'd0);
    run(2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
